// File: rtl/mult_hilo_unit_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the HI/LO multiply unit.
//   state_t  : control FSM states (IDLE, CALC, FIX)
//   MULT_W   : operand width
//   PROD_W   : product width (2 * MULT_W)
//   CNT_W    : width of the CALC cycle counter
// ---------------------------------------------------------------------------
package mult_pkg;

    localparam int MULT_W = 32;
    localparam int PROD_W = 64;
    localparam int CNT_W  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/mult_hilo_unit_if.sv
// ---------------------------------------------------------------------------
// mult_hilo_unit_if
// Request/response bundle between the execute-stage issuer and the
// multiply unit.
//   Issuer -> unit : start, is_signed, rs_val, rt_val, mthi, mtlo, wdata,
//                    rd_req
//   Unit -> issuer : hi, lo, busy, done, stall
// master = issuer side, slave = multiply unit side.
// ---------------------------------------------------------------------------
interface mult_hilo_unit_if #(
    parameter int WIDTH = 32
) ();

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             rd_req;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output start, is_signed, rs_val, rt_val, mthi, mtlo, wdata, rd_req,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  start, is_signed, rs_val, rt_val, mthi, mtlo, wdata, rd_req,
        output hi, lo, busy, done, stall
    );

endinterface

// File: rtl/mult_hilo_unit_dp.sv
// ---------------------------------------------------------------------------
// mult_shift_add_dp
// Shift-add datapath: holds the multiplicand and the 2W-bit product
// register, retires one multiplier bit per step and presents the
// sign-corrected product.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   i_load      : capture i_mcand and load {0, i_mplier} into prod
//   i_step      : perform one shift-add iteration
//   i_neg       : negate the product on the result output
//   i_mcand     : multiplicand magnitude
//   i_mplier    : multiplier magnitude
//   o_result    : final product (two's-complement negated when i_neg)
// ---------------------------------------------------------------------------
module mult_shift_add_dp
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic               i_step,
    input  logic               i_neg,
    input  logic [WIDTH-1:0]   i_mcand,
    input  logic [WIDTH-1:0]   i_mplier,
    output logic [2*WIDTH-1:0] o_result
);

    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH:0]     w_sum;

    // Carry out of the upper half is kept as bit W of the sum so the
    // right shift never loses it.
    assign w_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                 + (r_prod[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prod  <= '0;
            r_mcand <= '0;
        end else if (i_load) begin
            r_prod  <= {{WIDTH{1'b0}}, i_mplier};
            r_mcand <= i_mcand;
        end else if (i_step) begin
            r_prod  <= {w_sum, r_prod[WIDTH-1:1]};
        end
    end

    assign o_result = i_neg ? (~r_prod + 1'b1) : r_prod;

endmodule

// File: rtl/mult_hilo_unit.sv
// ---------------------------------------------------------------------------
// mult_hilo_unit
// Sequential MULT/MULTU unit with HI/LO architectural registers. Runs one
// multiplier bit per cycle, writes the product into HI/LO, services
// MTHI/MTLO writes while idle and stalls the pipeline while a product is
// pending.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : slave side of mult_hilo_unit_if (operands, MT writes, read
//           request in; hi, lo, busy, done, stall out)
// ---------------------------------------------------------------------------
module mult_hilo_unit
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_W
) (
    input  logic             clk,
    input  logic             reset,
    mult_hilo_unit_if.slave  bus
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_step;
    logic [WIDTH-1:0]   w_mcand;
    logic [WIDTH-1:0]   w_mplier;
    logic [2*WIDTH-1:0] w_result;

    assign w_accept = (r_state == IDLE) && bus.start;
    assign w_step   = (r_state == CALC);

    // Magnitudes are unsigned, so 0x80000000 negates to itself and is
    // still the right magnitude.
    assign w_mcand  = (bus.is_signed && bus.rs_val[WIDTH-1]) ? (~bus.rs_val + 1'b1)
                                                             : bus.rs_val;
    assign w_mplier = (bus.is_signed && bus.rt_val[WIDTH-1]) ? (~bus.rt_val + 1'b1)
                                                             : bus.rt_val;

    mult_shift_add_dp #(
        .WIDTH    (WIDTH)
    ) u_dp (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_accept),
        .i_step   (w_step),
        .i_neg    (r_neg),
        .i_mcand  (w_mcand),
        .i_mplier (w_mplier),
        .o_result (w_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        // start wins over a simultaneous MT write
                        r_state <= CALC;
                        r_cnt   <= '0;
                        r_neg   <= bus.is_signed & (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
                        r_busy  <= 1'b1;
                    end else begin
                        if (bus.mthi) r_hi <= bus.wdata;
                        if (bus.mtlo) r_lo <= bus.wdata;
                    end
                end
                CALC: begin
                    // Counter holds at WIDTH-1 on exit rather than wrapping.
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= FIX;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                FIX: begin
                    r_hi    <= w_result[2*WIDTH-1:WIDTH];
                    r_lo    <= w_result[WIDTH-1:0];
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.stall = r_busy & (bus.rd_req | bus.mthi | bus.mtlo | bus.start);

endmodule

// File: doc/mult_hilo_unit.md
# mult_hilo_unit

Sequential 32x32 multiply unit that sits between the MIPS execute-stage decode and the HI/LO architectural registers. It accepts MULT/MULTU operands and runs a shift-add loop on a 64-bit product register, one bit per cycle. It writes the 64-bit product into HI/LO and serves MFHI/MFLO/MTHI/MTLO. It stalls the pipeline while a product is pending.

## Interface
- `WIDTH`, 32: operand width. The product is 2*WIDTH.
- `clk`, input, 1: sole clock, rising edge.
- `reset`, input, 1: synchronous, active-high.
- `start`, input, 1: single-cycle request to begin a multiply.
- `is_signed`, input, 1: 1 for MULT, 0 for MULTU. Sampled with `start`.
- `rs_val`, input, WIDTH: multiplicand. Sampled with `start`.
- `rt_val`, input, WIDTH: multiplier. Sampled with `start`.
- `mthi`, input, 1: write `wdata` into HI.
- `mtlo`, input, 1: write `wdata` into LO.
- `wdata`, input, WIDTH: data for MTHI/MTLO.
- `rd_req`, input, 1: MFHI/MFLO read request this cycle.
- `hi`, output, WIDTH: HI register.
- `lo`, output, WIDTH: LO register.
- `busy`, output, 1: multiply in progress.
- `done`, output, 1: one-cycle pulse when HI/LO take a new product.
- `stall`, output, 1: combinational, equal to `busy & (rd_req | mthi | mtlo | start)`.

## Operation
- States:
  - IDLE -> CALC on `start`.
  - CALC runs for WIDTH cycles, counted by a cycle counter, then -> FIX.
  - FIX -> IDLE unconditionally.
- Capture on `start` in IDLE:
  - mcand = |rs_val| when signed, else rs_val.
  - prod = {WIDTH'b0, |rt_val|} when signed, else {WIDTH'b0, rt_val}.
  - neg = is_signed & (rs_val[MSB] ^ rt_val[MSB]).
  - Absolute value is two's-complement negation, treated as unsigned. 0x80000000 stays 0x80000000, which is correct as an unsigned magnitude.
- Each CALC cycle:
  - sum = {1'b0, prod[2W-1:W]} + (prod[0] ? mcand : 0), a (W+1)-bit value.
  - prod <= {sum, prod[W-1:1]}, i.e. a right shift that keeps the carry.
- FIX: {HI, LO} <= neg ? -prod : prod (2W-bit two's complement). `done` pulses in the following cycle.
- MTHI/MTLO are honoured only in IDLE with `start` low. Both may assert together and both registers are written.
- Requests ignored while busy:
  - `start` and `mthi`/`mtlo` are dropped.
  - `stall` holds the pipeline so the issuer re-presents them.
  - `rd_req` while busy only asserts `stall`.
- If `start` and `mthi`/`mtlo` assert together in IDLE, `start` wins and the writes are dropped.
- HI/LO keep their old values until FIX. Reads outside a multiply return the last product.

## Timing
- Reset values: `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, state = IDLE, counter = 0, prod = 0.
- Reset mid-operation returns to IDLE at the next edge. The partial product is discarded, HI/LO clear, and no `done` is produced.
- Latency, with E0 being the edge that samples `start`:
  - `busy` is high from after E0 through the cycle ending at E33.
  - HI/LO update at E33.
  - `done` is high for exactly one cycle after E33, with `busy` low in that cycle.
  - A new `start` is accepted at E34 at the earliest, i.e. in the cycle where `done` is high. Back-to-back throughput is one multiply per 34 cycles.
- MTHI/MTLO writes land at the sampling edge and are visible the next cycle.
- The counter is 6 bits, loads 0 at E0 and exits CALC when it reaches WIDTH-1. There is no wrap-around beyond that.

## Structure
- Package `mult_pkg` holds:
  - the state enum {IDLE, CALC, FIX};
  - `MULT_W` = 32 and `PROD_W` = 64;
  - a `CNT_W` = 6 localparam.
- Sub-module `mult_shift_add_dp` holds the datapath: the prod and mcand registers, the (W+1)-bit adder, the shift, and the final conditional negate.
- The top level holds the FSM, counter, sign capture, HI/LO registers, MT write logic and the stall logic.

## Test plan
- MULTU, rs = 5, rt = 0x76543211 -> at E33 HI = 0x00000002, LO = 0x4FA4FA55. `done` is high one cycle and `busy` drops in that cycle.
- MULT, rs = 0xFFFFFFFD (-3), rt = 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- Boundary operands:
  - MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001.
  - MULT 0x80000000 × 0x80000000 -> HI = 0x40000000, LO = 0.
- Requests while busy:
  - `start` at cycle 10 with new operands -> ignored and `stall` = 1.
  - `rd_req` at cycle 20 -> `stall` = 1, and HI/LO still hold the previous values until E33.
- MTHI 0x12345678 and MTLO 0x9ABCDEF0 in IDLE -> HI/LO read back next cycle. Repeated with `start` in the same cycle -> the MT writes are dropped and the product is written at E33.
- `reset` at E10 of a multiply -> the next cycle has `busy` = 0, HI = LO = 0, and no `done` pulse ever appears for that operation.
